// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings and
// operand-preparation helpers.
package addsub_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  function automatic logic op_inverts_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // With b inverted, a carry-in of ci makes OP_SBB compute a - b - !ci.
  function automatic logic op_carry_in(input op_e op, input logic ci);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = ci;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple slice; also reports the carry into its MSB so
// the top slice can derive signed overflow.
module addsub_slice
  import addsub_pipe_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s     = w_sum[CHUNK-1:0];
  assign co    = w_sum[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out by XOR.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ w_sum[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: N stages of CPS ripple slices each, registered
// carry between stages, global stall with valid/ready handshake.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             z,
  output logic             n
);

  localparam int unsigned SW = CHUNK * CPS;
  localparam int unsigned N  = WIDTH / SW;

  // Stage k registers hold the operands (upper bits still pending), the carry
  // into slice group k and the result bits completed so far.
  logic             r_v [0:N-1];
  logic [WIDTH-1:0] r_a [0:N-1];
  logic [WIDTH-1:0] r_b [0:N-1];
  logic             r_c [0:N-1];
  logic [WIDTH-1:0] r_s [0:N-1];

  logic             r_out_v;
  logic [WIDTH-1:0] r_out_s;
  logic             r_out_co;
  logic             r_out_ov;
  logic             r_out_z;
  logic             r_out_n;

  logic             w_en;
  op_e              w_op;
  logic [WIDTH-1:0] w_b_prep;
  logic             w_cin;
  logic [WIDTH-1:0] w_s  [0:N-1];
  logic             w_co [0:N-1];
  logic             w_cm [0:N-1][0:CPS-1];
  logic [WIDTH-1:0] w_fs;

  assign w_en     = !r_out_v || out_ready;
  assign in_ready = w_en;

  assign w_op     = op_e'(op);
  assign w_b_prep = op_inverts_b(w_op) ? ~b : b;
  assign w_cin    = op_carry_in(w_op, ci);

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (k * SW);
    logic [CPS:0]   w_cc;
    logic [SW-1:0]  w_sl;
    logic [WIDTH-1:0] w_ins;

    assign w_cc[0] = r_c[k];
    for (genvar i = 0; i < CPS; i++) begin : g_slice
      addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (r_a[k][k*SW + i*CHUNK +: CHUNK]),
        .b     (r_b[k][k*SW + i*CHUNK +: CHUNK]),
        .ci    (w_cc[i]),
        .s     (w_sl[i*CHUNK +: CHUNK]),
        .co    (w_cc[i+1]),
        .c_msb (w_cm[k][i])
      );
    end

    assign w_ins   = WIDTH'(w_sl) << (k * SW);
    assign w_s[k]  = (r_s[k] & ~MASK) | w_ins;
    assign w_co[k] = w_cc[CPS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v[0] <= 1'b0;
    end else if (w_en) begin
      r_v[0] <= in_valid;
      if (in_valid) begin
        r_a[0] <= a;
        r_b[0] <= w_b_prep;
        r_c[0] <= w_cin;
        r_s[0] <= '0;
      end
    end
  end

  // Operands shift forward untouched so each stage sees its own slice group;
  // finished low bits travel along in r_s so s emerges aligned.
  for (genvar k = 1; k < N; k++) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[k] <= 1'b0;
      end else if (w_en) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1]) begin
          r_a[k] <= r_a[k-1];
          r_b[k] <= r_b[k-1];
          r_c[k] <= w_co[k-1];
          r_s[k] <= w_s[k-1];
        end
      end
    end
  end

  assign w_fs = w_s[N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v  <= 1'b0;
      r_out_s  <= '0;
      r_out_co <= 1'b0;
      r_out_ov <= 1'b0;
      r_out_z  <= 1'b0;
      r_out_n  <= 1'b0;
    end else if (w_en) begin
      r_out_v <= r_v[N-1];
      if (r_v[N-1]) begin
        r_out_s  <= w_fs;
        r_out_co <= w_co[N-1];
        r_out_ov <= w_co[N-1] ^ w_cm[N-1][CPS-1];
        r_out_z  <= ~|w_fs;
        r_out_n  <= w_fs[WIDTH-1];
      end
    end
  end

  assign out_valid = r_out_v;
  assign s         = r_out_s;
  assign co        = r_out_co;
  assign ov        = r_out_ov;
  assign z         = r_out_z;
  assign n         = r_out_n;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe: default 32-bit instance plus a
// 16-bit CPS=1 instance.
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ci, co, ov, z, n;
  logic [1:0]  op;
  logic [31:0] a, b, s;

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h, ci_h, co_h, ov_h, z_h, n_h;
  logic [1:0]  op_h;
  logic [15:0] a_h, b_h, s_h;

  int n_total = 0;
  int n_bad   = 0;

  addsub_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov), .z(z), .n(n)
  );

  addsub_pipe #(.WIDTH(16), .CHUNK(4), .CPS(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .ci(ci_h), .op(op_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .s(s_h), .co(co_h), .ov(ov_h), .z(z_h), .n(n_h)
  );

  // Directed vectors; expected sum and {co,ov,z,n} worked out by hand.
  logic [31:0] va [8] = '{32'h00000001, 32'h00000005, 32'h7FFFFFFF, 32'h12345678,
                          32'h00000010, 32'h00000010, 32'h0000FFFF, 32'h00000000};
  logic [31:0] vb [8] = '{32'h00000002, 32'h00000005, 32'h00000001, 32'h11111111,
                          32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000};
  logic [1:0]  vop[8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
  logic        vci[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] vs [8] = '{32'h00000003, 32'h00000000, 32'h80000000, 32'h2345678A,
                          32'h0000000F, 32'h0000000E, 32'h00010000, 32'h80000000};
  logic [3:0]  vf [8] = '{4'b0000, 4'b1010, 4'b0101, 4'b0000,
                          4'b1000, 4'b1000, 4'b0000, 4'b0101};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    a  = va[i];
    b  = vb[i];
    op = vop[i];
    ci = vci[i];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 2'($urandom_range(0, 3));
    ci = 1'($urandom_range(0, 1));
  endtask

  task automatic one32(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic c,
                       input logic [31:0] es, input logic [3:0] ef);
    int lat;
    in_valid = 1'b1; a = x; b = y; op = o; ci = c;
    tick();
    idle();
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd4);
    check_eq({tag, "_s"}, 64'(s), 64'(es));
    check_eq({tag, "_flags"}, 64'({co, ov, z, n}), 64'(ef));
    tick();
    check_eq({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic one16(input string tag, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic c,
                       input logic [15:0] es, input logic [3:0] ef);
    int lat;
    in_valid_h = 1'b1; a_h = x; b_h = y; op_h = o; ci_h = c;
    tick();
    in_valid_h = 1'b0;
    lat = 0;
    while (!out_valid_h && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd4);
    check_eq({tag, "_s"}, 64'(s_h), 64'(es));
    check_eq({tag, "_flags"}, 64'({co_h, ov_h, z_h, n_h}), 64'(ef));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    rst = 1'b1; out_ready = 1'b1; out_ready_h = 1'b1;
    in_valid_h = 1'b0; a_h = '0; b_h = '0; op_h = 2'b00; ci_h = 1'b0;
    idle();
    tick();
    tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_s", 64'(s), 64'd0);
    check_eq("rst_flags", 64'({co, ov, z, n}), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    one32("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 4'b1010);
    one32("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 4'b1100);
    one32("sub_neg", OP_SUB, 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 4'b0001);
    one32("adc_ovf", OP_ADC, 32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 4'b0101);
    one32("sbb", OP_SBB, 32'd10, 32'd3, 1'b0, 32'd6, 4'b1000);

    // Back-to-back: beat t appears right after edge t+4.
    for (int t = 0; t < 14; t++) begin
      if (t < 8) drive(t);
      else idle();
      tick();
      check_eq($sformatf("b2b_valid%0d", t), 64'(out_valid), 64'((t >= 4 && t < 12) ? 1 : 0));
      if (out_valid && t >= 4 && t < 12) begin
        check_eq($sformatf("b2b_s%0d", t - 4), 64'(s), 64'(vs[t-4]));
        check_eq($sformatf("b2b_flags%0d", t - 4), 64'({co, ov, z, n}), 64'(vf[t-4]));
      end
    end

    // Stall with a full pipeline, then drain.
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(4 + t);
      tick();
    end
    idle();
    tick();
    check_eq("stall_valid", 64'(out_valid), 64'd1);
    for (int h = 0; h < 3; h++) begin
      check_eq($sformatf("stall_in_ready%0d", h), 64'(in_ready), 64'd0);
      check_eq($sformatf("stall_s%0d", h), 64'(s), 64'(vs[4]));
      check_eq($sformatf("stall_flags%0d", h), 64'({co, ov, z, n}), 64'(vf[4]));
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (got < 4) begin
          check_eq($sformatf("drain_s%0d", got), 64'(s), 64'(vs[4+got]));
          check_eq($sformatf("drain_flags%0d", got), 64'({co, ov, z, n}), 64'(vf[4+got]));
        end
        got++;
      end
      tick();
    end
    check_eq("drain_count", 64'(got), 64'd4);

    // Reset with three beats in flight.
    for (int t = 0; t < 3; t++) begin
      drive(t);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq($sformatf("midrst_quiet%0d", c), 64'(out_valid), 64'd0);
    end

    one16("w16_adc", OP_ADC, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 4'b0000);
    one16("w16_sbb", OP_SBB, 16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined adder/subtractor for the datapath ALU, successor to the fixed 32-bit chunked ripple adder. Splits operands into CHUNK-bit ripple slices and registers the carry every CPS slices, which trades latency for clock rate. Adds subtract and carry/borrow-in modes, result flags, and a valid/ready handshake with back-pressure.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of CHUNK*CPS
CHUNK, 4, bits per ripple slice
CPS, 2, slices per pipeline stage; stage count N = WIDTH/(CHUNK*CPS), default 4

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
ci  in  1  carry/borrow-in, used by op 10/11 only
op  in  2  00 add, 01 sub, 10 add+ci, 11 sub with borrow (a-b-!ci)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  result
co  out  1  carry out of MSB (sub: 1 = no borrow)
ov  out  1  signed overflow
z  out  1  s == 0
n  out  1  s[WIDTH-1]

Behaviour:
- One clock, clk; rst is synchronous active-high. Reset clears all stage valid bits and drives out_valid, s, co, ov, z, n to 0. in_ready reads 1 in the cycle after reset.
- Operand prep at input: sub ops invert b. Carry-in is 0 for op 00, 1 for op 01, ci for op 10, and ci for op 11. With b inverted, op 11 then computes a-b-!ci.
- Stage k (0..N-1) adds bits [k*CHUNK*CPS +: CHUNK*CPS] using the registered carry from stage k-1 (stage 0 uses the prepared carry-in).
- Skew: unprocessed upper operand bits shift forward with each stage. Completed lower result bits are carried forward (deskew) so the full s appears aligned at the output.
- The final stage output is registered; out_valid, s and flags come from that register.
- Latency: a result appears N cycles after the accept edge when there is no stall. Throughput is 1 beat/cycle.
- Global stall: en = !out_valid | out_ready; in_ready = en.
- When en=0, every stage register, including the valid bits and the output, holds. s and flags stay stable while out_valid=1 and out_ready=0.
- Accept occurs when in_valid & in_ready. A cycle with no accept inserts a bubble (stage valid = 0). Bubbles are not collapsed.
- A transfer occurs when out_valid & out_ready. Results stay in order.
- ov = carry into MSB XOR carry out of MSB, evaluated in the final stage.
- z = (s == 0). n = MSB of s.
- Flags are computed from the final aligned s, in the same cycle as s.
- in_valid=0 beats: a, b, op and ci are don't-care and must not affect state other than bubble insertion.
- Reset mid-flight discards all in-flight beats. No stale result may appear afterwards.
- Simultaneous accept and output transfer in the same cycle is legal and required at full throughput.

Decomposition:
- Shared package holds the op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBB=2'b11).
- Sub-module addsub_slice is combinational: CHUNK-bit ripple with inputs a, b, ci and outputs s, co, plus carry-into-MSB (c_msb) for the overflow calculation.
- Instantiate addsub_slice N*CPS times via generate. The top level owns all pipeline registers and the handshake.

Test Plan:
1. Default params, op=00, a=32'hFFFFFFFF, b=1, out_ready=1 -> after 4 cycles: s=0, co=1, z=1, ov=0, n=0.
2. op=01, a=32'h80000000, b=1 -> s=32'h7FFFFFFF, co=1, ov=1, n=0. Then a=0, b=1 -> s=32'hFFFFFFFF, co=0, n=1.
3. 8 back-to-back random beats with out_ready=1 -> one result per cycle starting at cycle 4, in order, all matching the reference model.
4. Fill pipeline, hold out_ready=0 for 3 cycles -> in_ready=0 and s/flags stable. Release -> 4 results drain in order with no loss or duplication.
5. rst asserted for 1 cycle with 3 beats in flight -> next cycle out_valid=0; no result emerges in the following 6 cycles.
6. WIDTH=16, CHUNK=4, CPS=1 (N=4): op=10, a=16'h00FF, b=1, ci=1 -> s=16'h0101 at latency 4. op=11, a=5, b=3, ci=0 -> s=1, co=1.
